// File: rtl/segment_digit_renderer.sv
// segment_digit_renderer
// Streams one on/off bit per pixel for a row of seven-segment digits.
// Digit values and masks are latched once per frame so the picture never tears.
// Fixed two-stage pipeline: stage 1 locates the pixel inside a digit cell,
// stage 2 decodes the segment and applies blank and blink.
module segment_digit_renderer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int COORD_W       = 10,
  parameter int NUM_DIGITS    = 8,
  parameter int DIGIT_WIDTH   = SCREEN_WIDTH / (2 * NUM_DIGITS),
  parameter int DIGIT_HEIGHT  = 2 * DIGIT_WIDTH,
  parameter int THICK         = DIGIT_WIDTH / 10,
  parameter int ORIGIN_X      = DIGIT_WIDTH / 2,
  parameter int ORIGIN_Y      = (SCREEN_HEIGHT - DIGIT_HEIGHT) / 2,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    pixel_valid,
  input  logic [COORD_W-1:0]      pixel_x,
  input  logic [COORD_W-1:0]      pixel_y,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    pixel_on,
  output logic                    pixel_on_valid
);

  localparam int PITCH = 2 * DIGIT_WIDTH;
  localparam int KW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [COORD_W-1:0] ORIGIN_X_C = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] ORIGIN_Y_C = COORD_W'(ORIGIN_Y);
  localparam logic [COORD_W-1:0] SPAN_C     = COORD_W'(PITCH * NUM_DIGITS);
  localparam logic [COORD_W-1:0] DW_C       = COORD_W'(DIGIT_WIDTH);
  localparam logic [COORD_W-1:0] DH_C       = COORD_W'(DIGIT_HEIGHT);
  localparam logic [COORD_W-1:0] THICK_C    = COORD_W'(THICK);
  localparam logic [COORD_W-1:0] BOT_C      = COORD_W'(DIGIT_HEIGHT - THICK);
  localparam logic [COORD_W-1:0] RIGHT_C    = COORD_W'(DIGIT_WIDTH - THICK);
  localparam logic [COORD_W-1:0] HALF_C     = COORD_W'(DIGIT_HEIGHT / 2);
  localparam logic [COORD_W-1:0] MID_LO_C   = COORD_W'(DIGIT_HEIGHT / 2 - THICK / 2);
  localparam logic [COORD_W-1:0] MID_HI_C   = COORD_W'(DIGIT_HEIGHT / 2 + THICK / 2);
  localparam logic [FW-1:0]      LAST_FR_C  = FW'(BLINK_FRAMES - 1);

  // Per-frame shadow copies of the display inputs and the blink state
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  // Stage 1 registers
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_inside_q, s1_inside_d;
  logic [KW-1:0]           s1_k_q, s1_k_d;
  logic [COORD_W-1:0]      s1_lx_q, s1_lx_d;
  logic [COORD_W-1:0]      s1_ly_q, s1_ly_d;

  // Stage 2 (output) registers
  logic                    pixel_on_q, pixel_on_d;
  logic                    pixel_on_valid_q, pixel_on_valid_d;

  logic [COORD_W-1:0]      dx;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_lit;
  logic [6:0]              seg_geom;

  // Latch display inputs on frame_start and advance the blink counter
  always_comb begin
    digits_d      = digits_q;
    blank_d       = blank_q;
    blink_d       = blink_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      digits_d = digits;
      blank_d  = blank_mask;
      blink_d  = blink_mask;
      if (frame_cnt_q == LAST_FR_C) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Stage 1: find the digit cell and the local coordinates inside it
  always_comb begin
    s1_valid_d = pixel_valid;
    dx         = pixel_x - ORIGIN_X_C;
    s1_k_d     = '0;
    s1_lx_d    = dx;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (dx >= COORD_W'(i * PITCH)) begin
        s1_k_d  = KW'(i);
        s1_lx_d = dx - COORD_W'(i * PITCH);
      end
    end
    s1_ly_d     = pixel_y - ORIGIN_Y_C;
    s1_inside_d = pixel_valid && (pixel_x >= ORIGIN_X_C) && (dx < SPAN_C) &&
                  (s1_lx_d < DW_C) && (pixel_y >= ORIGIN_Y_C) && (s1_ly_d < DH_C);
  end

  // Stage 2: decode the digit, test segment geometry, apply blank and blink
  always_comb begin
    cur_digit = digits_q[4*s1_k_q +: 4];
    case (cur_digit)
      4'd0:    seg_lit = 7'b1111110;
      4'd1:    seg_lit = 7'b0110000;
      4'd2:    seg_lit = 7'b1101101;
      4'd3:    seg_lit = 7'b1111001;
      4'd4:    seg_lit = 7'b0110011;
      4'd5:    seg_lit = 7'b1011011;
      4'd6:    seg_lit = 7'b1011111;
      4'd7:    seg_lit = 7'b1110000;
      4'd8:    seg_lit = 7'b1111111;
      4'd9:    seg_lit = 7'b1111011;
      default: seg_lit = 7'b0000000;
    endcase
    seg_geom[6] = (s1_ly_q < THICK_C);
    seg_geom[5] = (s1_lx_q >= RIGHT_C) && (s1_ly_q < HALF_C);
    seg_geom[4] = (s1_lx_q >= RIGHT_C) && (s1_ly_q >= HALF_C);
    seg_geom[3] = (s1_ly_q >= BOT_C);
    seg_geom[2] = (s1_lx_q < THICK_C) && (s1_ly_q >= HALF_C);
    seg_geom[1] = (s1_lx_q < THICK_C) && (s1_ly_q < HALF_C);
    seg_geom[0] = (s1_ly_q >= MID_LO_C) && (s1_ly_q < MID_HI_C);
    pixel_on_valid_d = s1_valid_q;
    pixel_on_d = s1_valid_q && s1_inside_q && (|(seg_lit & seg_geom)) &&
                 !blank_q[s1_k_q] && !(blink_q[s1_k_q] && blink_phase_q);
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q         <= '1;
      blank_q          <= '0;
      blink_q          <= '0;
      frame_cnt_q      <= '0;
      blink_phase_q    <= 1'b0;
      s1_valid_q       <= 1'b0;
      s1_inside_q      <= 1'b0;
      s1_k_q           <= '0;
      s1_lx_q          <= '0;
      s1_ly_q          <= '0;
      pixel_on_q       <= 1'b0;
      pixel_on_valid_q <= 1'b0;
    end else begin
      digits_q         <= digits_d;
      blank_q          <= blank_d;
      blink_q          <= blink_d;
      frame_cnt_q      <= frame_cnt_d;
      blink_phase_q    <= blink_phase_d;
      s1_valid_q       <= s1_valid_d;
      s1_inside_q      <= s1_inside_d;
      s1_k_q           <= s1_k_d;
      s1_lx_q          <= s1_lx_d;
      s1_ly_q          <= s1_ly_d;
      pixel_on_q       <= pixel_on_d;
      pixel_on_valid_q <= pixel_on_valid_d;
    end
  end

  assign pixel_on       = pixel_on_q;
  assign pixel_on_valid = pixel_on_valid_q;

endmodule

// File: doc/segment_digit_renderer.md
Name: segment_digit_renderer

Overview:
- Streaming successor to the full-frame image drawer. Produces one on/off bit per pixel, in raster order, for a row of NUM_DIGITS seven-segment digits.
- Sits between the VGA timing generator, which supplies pixel coordinates, and the colour output stage. No frame buffer.
- Adds per-frame value latching (no tearing), per-digit blanking, per-digit blinking and a fixed 2-cycle pipeline.

Parameters:
- SCREEN_WIDTH, 640, active pixels per line.
- SCREEN_HEIGHT, 480, active lines per frame.
- COORD_W, 10, width of pixel_x/pixel_y.
- NUM_DIGITS, 8, number of digit cells; digit 0 is leftmost.
- DIGIT_WIDTH, SCREEN_WIDTH/(2*NUM_DIGITS) = 40, digit cell width in pixels. Digit pitch is 2*DIGIT_WIDTH.
- DIGIT_HEIGHT, 2*DIGIT_WIDTH = 80, digit height in pixels.
- THICK, DIGIT_WIDTH/10 = 4, segment stroke width in pixels.
- ORIGIN_X, DIGIT_WIDTH/2 = 20, x of digit 0 left edge.
- ORIGIN_Y, (SCREEN_HEIGHT-DIGIT_HEIGHT)/2 = 200, y of digit top edge.
- BLINK_FRAMES, 30, frames per blink half-period (minimum 1).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse at the start of each frame.
- pixel_valid  in  1  pixel_x/pixel_y are valid this cycle.
- pixel_x  in  COORD_W  column.
- pixel_y  in  COORD_W  row.
- digits  in  4*NUM_DIGITS  BCD values; digit k in bits [4k+3:4k].
- blank_mask  in  NUM_DIGITS  bit k=1 forces digit k dark.
- blink_mask  in  NUM_DIGITS  bit k=1 makes digit k blink.
- pixel_on  out  1  pixel lit.
- pixel_on_valid  out  1  pixel_on qualifier.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. Everything else is synchronous to the rising edge of clk.
- Reset values:
  - pixel_on=0, pixel_on_valid=0, pipeline valids=0.
  - Shadow digits=4'hF (blank), shadow masks=0.
  - frame_cnt=0, blink_phase=0.
- Latching: on a clk edge with frame_start=1, register digits, blank_mask and blink_mask into shadow registers. These hold for the whole frame; input changes mid-frame have no visible effect.
- Pixel with frame_start and pixel_valid in the same cycle: rendered with the newly latched values.
- Pipeline latency is exactly 2 cycles: pixel_on_valid(t+2)=pixel_valid(t). pixel_on is 0 whenever pixel_on_valid is 0.
  - Stage 1: region test, digit index k, local lx, ly.
  - Stage 2: segment decode and output.
  - No stalls. Back-to-back pixels are accepted every cycle.
- Region test: k = (pixel_x-ORIGIN_X)/(2*DIGIT_WIDTH), lx = offset within the pitch, ly = pixel_y-ORIGIN_Y. The pixel is inside a digit only if all of these hold, otherwise pixel_on=0:
  - pixel_x >= ORIGIN_X
  - k < NUM_DIGITS
  - lx < DIGIT_WIDTH
  - 0 <= ly < DIGIT_HEIGHT
- Segment geometry, in local coordinates:
  - a: ly<THICK.
  - d: ly>=DIGIT_HEIGHT-THICK.
  - g: DIGIT_HEIGHT/2-THICK/2 <= ly < DIGIT_HEIGHT/2+THICK/2.
  - f: lx<THICK and ly<DIGIT_HEIGHT/2.
  - b: lx>=DIGIT_WIDTH-THICK and ly<DIGIT_HEIGHT/2.
  - e: lx<THICK and ly>=DIGIT_HEIGHT/2.
  - c: lx>=DIGIT_WIDTH-THICK and ly>=DIGIT_HEIGHT/2.
- Decode table:
  - 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg.
  - 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
  - Codes 10-15 = no segments (blank).
- pixel_on = (pixel in a lit segment of digit k) AND NOT shadow_blank[k] AND NOT (shadow_blink[k] AND blink_phase).
- Blink counter:
  - Each frame_start increments frame_cnt.
  - When frame_cnt = BLINK_FRAMES-1 and frame_start=1: frame_cnt wraps to 0 and blink_phase toggles.
  - With default BLINK_FRAMES=30, phase changes every 30 frames.
- Reset mid-frame: outputs drop immediately (asynchronously). The first pixel_on_valid after release is 2 cycles after the first accepted pixel_valid. Digits stay blank until the next frame_start.

Test Plan:
- Reset: hold rst_n=0 with pixel_valid=1 -> pixel_on=0, pixel_on_valid=0. Release, then drive pixel (40,240) without frame_start -> pixel_on=0, because shadow is blank.
- Latency and shape, with frame_start and digits[3:0]=0:
  - (20,200) -> pixel_on=1 exactly 2 cycles later (segments a/f).
  - (40,240) -> 0 (g unlit).
  - Then latch 8 -> (40,240) -> 1.
  - Gap (70,240) -> 0, always.
- Tearing: latch 1 into digit 1. Mid-frame change digits[7:4] to 8 -> (102,240) stays 0 until the next frame_start, then 1.
- Blank: blank_mask[0]=1 with digit 8 -> every pixel in x 20..59, y 200..279 gives 0. Code 4'hC with mask 0 -> also 0.
- Blink: blink_mask[0]=1, digit 8:
  - Frames 1-29 -> (40,240)=1.
  - After the 30th frame_start -> 0.
  - After the 60th -> 1.
- Throughput and reset: stream 640 consecutive pixels of row 240 -> 640 consecutive pixel_on_valid cycles. Assert rst_n=0 mid-row -> pixel_on_valid=0 immediately, and frame_cnt=0 afterwards.
